// File: rtl/uart_tx_fifo.sv
// Purpose: byte FIFO feeding the UART serializer through a tx_load/tx_done handshake.
// Latency: a byte written into an empty, idle FIFO is popped one edge later; tx_load pulses in the following cycle.
// Backpressure: writes while full are dropped and latch the sticky overflow flag; the drain waits on tx_done.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [7:0]    tx_data,
    output logic          tx_load,
    input  logic          tx_done
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count_nxt;
    logic            pop;
    logic            wr_acc;
    logic            ovf_set;

    // Full is judged before any pop on the same edge, so a write into a
    // full buffer is dropped even if a byte leaves in that cycle.
    assign wr_acc  = wr_en && !full && !flush;
    assign ovf_set = wr_en &&  full && !flush;

    // Drain FSM: decides when to pop and drives the one-cycle tx_load.
    // A flush suppresses a due pop and parks the FSM in IDLE instead.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        tx_load   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty && !flush) begin
                    pop       = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_load   = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done) begin
                    if (!empty && !flush) begin
                        pop       = 1'b1;
                        state_nxt = ST_LOAD;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Occupancy after this edge; a simultaneous write and pop cancel out.
    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else begin
            case ({wr_acc, pop})
                2'b10:   count_nxt = count + CNT_ONE;
                2'b01:   count_nxt = count - CNT_ONE;
                default: count_nxt = count;
            endcase
        end
    end

    // Storage array; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy, registered flags and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                if (ovf_set) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // FSM state register and the byte handed to the serializer; flush
    // leaves both alone so an already loaded frame runs to completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            tx_data <= 8'h00;
        end else begin
            state <= state_nxt;
            if (pop) begin
                tx_data <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer and drain controller directly upstream of the UART transmitter.
- Accepts bytes from the host or bus side through a write strobe and stores them in a power-of-two circular buffer.
- Hands one byte at a time to the serializer with a load/done handshake, so the host never has to time writes against the baud rate.
- Its tx_data output drives the transmitter's tx_dfifo input.

Parameters:
- DEPTH, 16: number of byte entries; power of two, at least 2.
- AW, 4: pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous clear of buffered bytes.
- wr_en  in  1  write strobe; one byte per cycle.
- wr_data  in  8  byte to enqueue.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  AW+1  number of stored bytes, 0..DEPTH.
- overflow  out  1  sticky flag: a write was dropped because the buffer was full.
- tx_data  out  8  registered byte presented to the transmitter.
- tx_load  out  1  one-cycle pulse: tx_data is valid, start a frame.
- tx_done  in  1  one-cycle pulse from the transmitter: frame finished, including stop bit.

Behaviour:
- Reset (rst=1 at an edge):
  - wr_ptr, rd_ptr, count = 0; overflow = 0; tx_data = 8'h00; tx_load = 0; state = IDLE.
  - Results: empty=1, full=0.
  - Reset mid-frame abandons the frame. A tx_done arriving after reset is ignored, because the state is IDLE.
- Storage: DEPTH x 8 register array; wr_ptr and rd_ptr are AW bits and wrap modulo DEPTH.
- Write:
  - wr_en=1 and full=0 at an edge: mem[wr_ptr] <= wr_data; wr_ptr+1.
  - wr_en=1 and full=1: byte dropped, pointers unchanged, overflow <= 1.
- Pop: occurs only on an FSM transition into LOAD. At that edge, tx_data <= mem[rd_ptr] and rd_ptr+1.
- count update per edge: +1 on write only, -1 on pop only, unchanged when both or neither occur.
- full, empty and count are registered and reflect the state after the last edge.
- FSM, with state registered:
  - IDLE: if count != 0, pop and go to LOAD; otherwise stay in IDLE.
  - LOAD: tx_load = 1 for exactly this cycle; unconditionally go to WAIT. A tx_done seen in LOAD is ignored.
  - WAIT: if tx_done=1 and count != 0, pop and go to LOAD (back-to-back frames). If tx_done=1 and count == 0, go to IDLE. Otherwise stay in WAIT.
- Latency:
  - A write accepted at edge E into an empty buffer in IDLE gives a pop at edge E+1.
  - tx_load is high during the cycle between E+1 and E+2.
  - tx_data is stable from edge E+1 until the next pop.
- Simultaneous events:
  - Write and pop on the same edge: both take effect, count unchanged.
  - Write while full on the same edge as a pop: still dropped, because full is evaluated before the pop.
  - Empty plus write: the byte is not visible to the FSM until the next edge; there is no bypass.
- flush=1 at an edge:
  - wr_ptr, rd_ptr, count = 0; overflow = 0.
  - Any write in that cycle is discarded.
  - The FSM and tx_data are unaffected: a byte already loaded completes its LOAD/WAIT sequence.
  - flush has priority over wr_en and over any pop in that cycle. If a pop is due in that cycle, the FSM instead stays in, or returns to, IDLE.
- rst has priority over flush.

Test Plan:
- Reset, then idle 10 cycles -> empty=1, count=0, tx_load never asserted, tx_data=8'h00, overflow=0.
- Single write 8'hA5 at edge E -> tx_load high in the cycle after E+1, tx_data=8'hA5, count returns to 0. No second tx_load until tx_done and a new write.
- Burst of 3 writes (11,22,33) on consecutive cycles; tx_done pulsed 20 cycles after each tx_load -> three tx_load pulses, each exactly 1 cycle after the preceding tx_done edge. tx_data sequence is 11,22,33; FSM ends in IDLE.
- With tx_done held low, write DEPTH+2 bytes -> full=1 at count=16 (one byte already popped into tx_data, so 17 writes accepted). Remaining write dropped; overflow=1 and stays 1 until flush.
- When full, wr_en on the same edge that tx_done triggers a pop -> write dropped, count 16->15, overflow set.
- Mid-frame: flush with 5 bytes queued while in WAIT -> count=0, overflow=0. Current tx_data held, next tx_done returns the FSM to IDLE with no further tx_load. Repeat with rst in WAIT -> all outputs at reset values the next cycle, and a later tx_done causes no tx_load.
